// File: rtl/seg_frame_buffer.sv
// rtl/seg_frame_buffer.sv - double-buffered six-digit 7-segment frame store
//
// Purpose: control logic writes digits into a back buffer and requests a
// commit; the back buffer is copied to the front buffer only at a scan-frame
// boundary (slot 5 edge) so a displayed frame never tears. Front entries are
// decoded to active-low segment patterns (bit7 = dot, bits6:0 = g..a).
//
// Optional feature macro: SEG_FRAME_FLASH_EN (flash counter and flash gating).
//
// Ports:
//   clk_833us               scan tick clock
//   rst                     asynchronous active-low reset
//   wr_en, wr_addr          back-buffer write strobe / digit index (6,7 ignored)
//   wr_digit, wr_dot,
//   wr_blank, wr_flash      entry fields written into the back buffer
//   commit                  request a back->front swap
//   busy                    a commit is pending
//   commit_ack              one-cycle pulse in the cycle after the swap
//   frame_start             high while the slot counter is 0
//   flash_phase             blink phase, 1 = flashing digits off
//   seg_data_0..seg_data_5  registered active-low segment outputs

module seg_frame_buffer #(
    parameter int FLASH_HALF_FRAMES = 50
) (
    input  logic       clk_833us,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_digit,
    input  logic       wr_dot,
    input  logic       wr_blank,
    input  logic       wr_flash,
    input  logic       commit,
    output logic       busy,
    output logic       commit_ack,
    output logic       frame_start,
    output logic       flash_phase,
    output logic [7:0] seg_data_0,
    output logic [7:0] seg_data_1,
    output logic [7:0] seg_data_2,
    output logic [7:0] seg_data_3,
    output logic [7:0] seg_data_4,
    output logic [7:0] seg_data_5
);

    // Entry layout: [6:3] digit, [2] dot, [1] blank, [0] flash.
    localparam logic [6:0] ENTRY_RESET = 7'b0000_010;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       swap;
    logic [2:0] slot_q;
    logic       boundary;
    logic       commit_ack_q;
    logic       flash_gate_d;

    logic [6:0] back_q  [6];
    logic [6:0] front_q [6];
    logic [6:0] front_d [6];
    logic [7:0] seg_q   [6];

    // Half-period must be at least one frame.
    if (FLASH_HALF_FRAMES < 1) begin : g_bad_half_frames
    end

    function automatic logic [7:0] decode(input logic [6:0] entry, input logic phase);
        logic [7:0] pat;
        case (entry[6:3])
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        pat[7] = ~entry[2];
        if (entry[1] || (entry[0] && phase)) begin
            pat = 8'hFF;
        end
        return pat;
    endfunction

    // Slot counter mirrors the scan stage digit select; slot 5 closes a frame.
    assign boundary    = (slot_q == 3'd5);
    assign frame_start = (slot_q == 3'd0);

    always_ff @(posedge clk_833us or negedge rst) begin
        if (!rst) begin
            slot_q <= 3'd0;
        end else begin
            slot_q <= boundary ? 3'd0 : slot_q + 3'd1;
        end
    end

    // Commit sequencing: a commit seen while pending is dropped.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_833us or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            commit_ack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            commit_ack_q <= swap;
        end
    end

    assign busy       = (state_q == PENDING);
    assign commit_ack = commit_ack_q;

    // Front buffer takes the pre-edge back contents, so a write landing on
    // the swap edge only reaches the back buffer.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            front_d[i] = swap ? back_q[i] : front_q[i];
        end
    end

    always_ff @(posedge clk_833us or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                back_q[i]  <= ENTRY_RESET;
                front_q[i] <= ENTRY_RESET;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                front_q[i] <= front_d[i];
            end
            if (wr_en && (wr_addr <= 3'd5)) begin
                back_q[wr_addr] <= {wr_digit, wr_dot, wr_blank, wr_flash};
            end
        end
    end

`ifdef SEG_FRAME_FLASH_EN
    localparam int FCW = (FLASH_HALF_FRAMES > 1) ? $clog2(FLASH_HALF_FRAMES) : 1;

    logic [FCW-1:0] flash_cnt_q;
    logic           flash_phase_q, flash_phase_d;
    logic           flash_wrap;

    assign flash_wrap = (flash_cnt_q == FCW'(FLASH_HALF_FRAMES - 1));

    always_comb begin
        flash_phase_d = flash_phase_q;
        if (boundary && flash_wrap) begin
            flash_phase_d = ~flash_phase_q;
        end
    end

    always_ff @(posedge clk_833us or negedge rst) begin
        if (!rst) begin
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else begin
            if (boundary) begin
                flash_cnt_q <= flash_wrap ? '0 : flash_cnt_q + 1'b1;
            end
            flash_phase_q <= flash_phase_d;
        end
    end

    assign flash_phase  = flash_phase_q;
    assign flash_gate_d = flash_phase_d;
`else
    assign flash_phase  = 1'b0;
    assign flash_gate_d = 1'b0;
`endif

    // Outputs are decoded from the next-state front buffer and phase so a
    // swap shows up in the same cycle as commit_ack.
    always_ff @(posedge clk_833us or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= 8'hFF;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= decode(front_d[i], flash_gate_d);
            end
        end
    end

    assign seg_data_0 = seg_q[0];
    assign seg_data_1 = seg_q[1];
    assign seg_data_2 = seg_q[2];
    assign seg_data_3 = seg_q[3];
    assign seg_data_4 = seg_q[4];
    assign seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_seg_frame_buffer.sv
// tb/tb_seg_frame_buffer.sv - scoreboard bench for seg_frame_buffer
module tb_seg_frame_buffer;

    localparam int HALF = 2;
`ifdef SEG_FRAME_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic       clk_833us = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_digit = 4'd0;
    logic       wr_dot = 1'b0;
    logic       wr_blank = 1'b0;
    logic       wr_flash = 1'b0;
    logic       commit = 1'b0;
    logic       busy, commit_ack, frame_start, flash_phase;
    logic [7:0] seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5;

    seg_frame_buffer #(.FLASH_HALF_FRAMES(HALF)) dut (
        .clk_833us  (clk_833us),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_digit   (wr_digit),
        .wr_dot     (wr_dot),
        .wr_blank   (wr_blank),
        .wr_flash   (wr_flash),
        .commit     (commit),
        .busy       (busy),
        .commit_ack (commit_ack),
        .frame_start(frame_start),
        .flash_phase(flash_phase),
        .seg_data_0 (seg_data_0),
        .seg_data_1 (seg_data_1),
        .seg_data_2 (seg_data_2),
        .seg_data_3 (seg_data_3),
        .seg_data_4 (seg_data_4),
        .seg_data_5 (seg_data_5)
    );

    always #5 clk_833us = ~clk_833us;

    int total = 0;
    int bad = 0;

    // Reference model: n = clock edges since reset release.
    int         n;
    logic [3:0] b_dig [6];
    logic       b_dot [6], b_blk [6], b_fl [6];
    logic [3:0] f_dig [6];
    logic       f_dot [6], f_blk [6], f_fl [6];
    bit         m_pend, m_ack;
    logic [47:0] exp_q [$];

    function automatic logic [7:0] hexseg(input logic [3:0] d);
        case (d)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic bit m_phase();
        return FLASH_ON && ((((n / 6) / HALF) % 2) == 1);
    endfunction

    function automatic logic [7:0] m_seg(input int i);
        logic [7:0] p;
        if (f_blk[i]) return 8'hFF;
        if (f_fl[i] && m_phase()) return 8'hFF;
        p = hexseg(f_dig[i]);
        p[7] = ~f_dot[i];
        return p;
    endfunction

    function automatic logic [47:0] m_frame();
        logic [47:0] fr;
        for (int i = 0; i < 6; i++) fr[i*8 +: 8] = m_seg(i);
        return fr;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got %02h expected %02h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_pend = 0;
        m_ack = 0;
        for (int i = 0; i < 6; i++) begin
            b_dig[i] = 0; b_dot[i] = 0; b_blk[i] = 1; b_fl[i] = 0;
            f_dig[i] = 0; f_dot[i] = 0; f_blk[i] = 1; f_fl[i] = 0;
        end
    endtask

    task automatic model_edge(input logic we, input logic [2:0] a, input logic [3:0] d,
                              input logic dt, input logic bl, input logic fl, input logic cm);
        bit sw;
        sw = m_pend && ((n % 6) == 5);
        if (sw) begin
            for (int i = 0; i < 6; i++) begin
                f_dig[i] = b_dig[i]; f_dot[i] = b_dot[i]; f_blk[i] = b_blk[i]; f_fl[i] = b_fl[i];
            end
            m_pend = 0;
        end else if (!m_pend && cm) begin
            m_pend = 1;
        end
        m_ack = sw;
        if (we && a <= 3'd5) begin
            b_dig[a] = d; b_dot[a] = dt; b_blk[a] = bl; b_fl[a] = fl;
        end
        n++;
        if (sw) exp_q.push_back(m_frame());
    endtask

    task automatic check_outputs();
        logic [47:0] act;
        act = {seg_data_5, seg_data_4, seg_data_3, seg_data_2, seg_data_1, seg_data_0};
        for (int i = 0; i < 6; i++) chk($sformatf("seg_data_%0d", i), act[i*8 +: 8], m_seg(i));
        chk("busy", {7'd0, busy}, {7'd0, m_pend});
        chk("commit_ack", {7'd0, commit_ack}, {7'd0, m_ack});
        chk("frame_start", {7'd0, frame_start}, {7'd0, (n % 6) == 0});
        chk("flash_phase", {7'd0, flash_phase}, {7'd0, m_phase()});
    endtask

    task automatic step(input logic we, input logic [2:0] a, input logic [3:0] d,
                        input logic dt, input logic bl, input logic fl, input logic cm);
        check_outputs();
        wr_en = we; wr_addr = a; wr_digit = d; wr_dot = dt; wr_blank = bl; wr_flash = fl; commit = cm;
        model_edge(we, a, d, dt, bl, fl, cm);
        @(posedge clk_833us);
        @(negedge clk_833us);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic to_slot(input int s);
        for (int i = 0; i < 6 && (n % 6) != s; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_en = 0; commit = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_833us);
        @(negedge clk_833us);
        check_outputs();
        rst = 1'b1;
    endtask

    // Monitor: every commit_ack must match the frame queued at the swap.
    always @(negedge clk_833us) begin
        if (rst === 1'b1 && commit_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: got commit_ack=1 expected no pending frame");
            end else begin
                logic [47:0] e;
                logic [47:0] a;
                e = exp_q.pop_front();
                a = {seg_data_5, seg_data_4, seg_data_3, seg_data_2, seg_data_1, seg_data_0};
                for (int i = 0; i < 6; i++) chk($sformatf("ack_frame_%0d", i), a[i*8 +: 8], e[i*8 +: 8]);
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk_833us);
        do_reset();
        idle(12);

        // Digits 1..6, commit at slot 0.
        for (int i = 0; i < 6; i++) step(1, 3'(i), 4'(i + 1), 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(8);

        // Tear-free: rewrite at slot 3 joins the swap, write on the swap edge does not.
        to_slot(0);
        step(0, 0, 0, 0, 0, 0, 1);
        to_slot(3);
        step(1, 2, 8, 0, 0, 0, 0);
        to_slot(5);
        step(1, 2, 9, 0, 0, 0, 0);
        idle(7);
        to_slot(0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(7);

        // Boundary commit and an ignored second commit.
        to_slot(5);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(8);

        // Decode corner cases.
        step(1, 0, 4'hA, 1, 0, 0, 0);
        step(1, 1, 4'h3, 1, 1, 0, 0);
        step(1, 7, 4'h5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(7);

        // Flash on digit 0.
        step(1, 0, 4'h0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(60);

        // Reset while a commit is pending.
        step(1, 4, 4'h7, 0, 0, 0, 1);
        idle(2);
        do_reset();
        idle(8);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end
        idle(8);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL ack_count: got %0d frames never acknowledged expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_frame_buffer.md
# seg_frame_buffer

Double-buffered six-digit display frame store feeding the six `seg_data_N` inputs of the segment scan stage. Control logic writes digits (hex value, dot, blank, flash) into a back buffer and requests a commit. The block swaps the back buffer into the front buffer only at a scan-frame boundary, so a displayed frame never tears. Front-buffer digits are decoded to active-low 7-segment plus dot patterns, with flash gating applied.

## Interface
Parameters:
- `FLASH_HALF_FRAMES`, default 50 — frames per flash half-period (50 × 5 ms = 250 ms, i.e. 2 Hz blink).

Ports:
- `clk_833us`  in  1  — scan tick clock, the same tick that advances the scan stage.
- `rst`  in  1  — reset, asynchronous, active-low.
- `wr_en`  in  1  — write strobe into the back buffer.
- `wr_addr`  in  3  — digit index 0..5; values 6 and 7 are ignored.
- `wr_digit`  in  4  — hex value 0x0..0xF.
- `wr_dot`  in  1  — 1 lights the decimal point.
- `wr_blank`  in  1  — 1 blanks the digit (all segments off).
- `wr_flash`  in  1  — 1 enables blinking for the digit.
- `commit`  in  1  — request a back→front swap.
- `busy`  out  1  — a commit is pending.
- `commit_ack`  out  1  — one-cycle pulse after the swap.
- `frame_start`  out  1  — high while the slot counter is 0.
- `flash_phase`  out  1  — current blink phase; 1 = flashing digits off.
- `seg_data_0` .. `seg_data_5`  out  8 each — active-low segments; bit7 = dot, bits6:0 = g..a.

## Operation
- **Buffers:** back and front buffers each hold 6 entries of {digit[3:0], dot, blank, flash}.
- **Back-buffer writes:** take effect on the edge where `wr_en`=1 and `wr_addr`≤5. An out-of-range address is a no-op.
- **Slot counter (3 bits):** counts 0,1,2,3,4,5,0… once per edge, mirroring the scan stage's digit select.
  - Both blocks leave reset together, so slot N coincides with digit N being scanned.
  - A frame is one pass 0..5. The frame boundary is the edge at which slot==5.
- **Commit sequencing:**
  - IDLE: `commit`=1 → PENDING (`busy`=1).
  - PENDING: at the boundary edge, front ← back, state → IDLE, `commit_ack`=1 for exactly the next cycle.
  - `commit` asserted while in PENDING is ignored; there is no queueing.
  - `commit` sampled on a boundary edge while in IDLE sets PENDING only. The swap occurs at the following boundary, 6 cycles later.
- **Writes during PENDING:** allowed and included in the swap if they occur strictly before the swap edge. A write on the swap edge updates the back buffer only; the front buffer receives the pre-edge back contents.
- **Decode (per front entry):**
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E. These are bits6:0 with bit7=1; bit7 is then replaced by ~dot.
  - blank=1 → 8'hFF, dot ignored.
  - flash=1 and `flash_phase`=1 → 8'hFF.
- **Flash counter:** advances at each boundary edge. On reaching `FLASH_HALF_FRAMES`−1 it wraps to 0 and toggles `flash_phase`.

## Timing
- **Reset values** (asynchronous, while `rst`=0):
  - Both buffers: all entries blank=1, digit=0, dot=0, flash=0.
  - All `seg_data_N` = 8'hFF.
  - Slot=0, `frame_start`=1.
  - `busy`=0, `commit_ack`=0, `flash_phase`=0, flash counter=0.
- **Output registration:** `seg_data_N` are registered and recomputed every edge from the front buffer and `flash_phase`. A swap appears on `seg_data_N` one cycle after the swap edge, the same cycle as `commit_ack`.
- **Commit latency:** from the edge sampling `commit` to the swap edge is 1..6 cycles. A commit on the slot-5 edge takes 6.
- **Cycle timing:** one cycle = 833 µs, one frame = 6 cycles ≈ 5 ms, one blink period = 2 × `FLASH_HALF_FRAMES` frames.
- **Reset mid-operation:** deasserting `rst` restarts from the reset state. A pending commit is discarded and back-buffer contents are lost.

## Configuration
- `SEG_FRAME_FLASH_EN` defined: flash counter and flash gating are present as described.
- `SEG_FRAME_FLASH_EN` undefined:
  - Flash counter is removed and `flash_phase` is tied to 0.
  - Stored flash bits are ignored; `wr_flash` is accepted but has no effect on outputs.

## Test plan
- Reset release: after reset, all `seg_data_N`=8'hFF and `frame_start` is high every 6th cycle starting at cycle 0. Then write digits 1,2,3,4,5,6 to addresses 0..5 and commit at slot 0 → `busy`=1 for cycles through slot 5; `commit_ack` at the next slot 0; `seg_data_0..5` = F9,A4,B0,99,92,82.
- Tear-free: commit, then rewrite address 2 with digit 8 at slot 3 → swapped frame shows 80 on `seg_data_2`. A write of digit 9 at the slot-5 swap edge does not appear until the next commit.
- Boundary commit: `commit` on a slot-5 edge → swap at the next slot-5 edge (6 cycles); a second `commit` during PENDING produces only one `commit_ack`.
- Decode: digit A with dot → 8'h08; blank with dot → 8'hFF; address 7 write → no change.
- Flash (`SEG_FRAME_FLASH_EN`, `FLASH_HALF_FRAMES`=2): digit 0 with flash → `seg_data_0` alternates C0 for 12 cycles and FF for 12 cycles. Without the macro it stays C0.
- Mid-operation reset: reset asserted while `busy`=1 → after release, `busy`=0, no `commit_ack`, all outputs FF.
